// File: rtl/reg_file_scoreboard_if.sv
// Decode/writeback bundle for reg_file_scoreboard: two read ports, issue handshake, writeback.
// master = decode/writeback side driving requests, slave = the register file.
interface reg_file_scoreboard_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] rd_addr_a;
  logic [DATA_WIDTH-1:0] rd_data_a;
  logic                  rd_ready_a;
  logic [ADDR_WIDTH-1:0] rd_addr_b;
  logic [DATA_WIDTH-1:0] rd_data_b;
  logic                  rd_ready_b;
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_dest;
  logic                  issue_ready;
  logic                  wb_valid;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_err;

  modport master (
    output rd_addr_a, rd_addr_b, issue_valid, issue_dest, wb_valid, wb_addr, wb_data,
    input  rd_data_a, rd_ready_a, rd_data_b, rd_ready_b, issue_ready, wb_err
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, issue_valid, issue_dest, wb_valid, wb_addr, wb_data,
    output rd_data_a, rd_ready_a, rd_data_b, rd_ready_b, issue_ready, wb_err
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Register file with per-register pending scoreboard gating issue on RAW/WAW hazards.
// Optional write-through forwarding when RFSB_BYPASS_EN is defined.
module reg_file_scoreboard #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input logic                  clk,
  input logic                  rst,
  reg_file_scoreboard_if.slave bus
);
  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NumRegs];
  logic [NumRegs-1:0]    pending_q;
  logic                  wb_err_q;

  logic                  wb_hit;
  logic                  issue_fire;
  logic [NumRegs-1:0]    pending_eff;

  assign wb_hit     = bus.wb_valid && (bus.wb_addr != '0);
  assign issue_fire = bus.issue_valid && bus.issue_ready && (bus.issue_dest != '0);

  always_comb begin
    pending_eff = pending_q;
`ifdef RFSB_BYPASS_EN
    // A writeback landing this cycle already counts as cleared for hazard checks.
    if (wb_hit) pending_eff[bus.wb_addr] = 1'b0;
`endif
  end

  always_comb begin
    bus.rd_data_a  = (bus.rd_addr_a == '0) ? '0 : regs_q[bus.rd_addr_a];
    bus.rd_ready_a = (bus.rd_addr_a == '0) || !pending_eff[bus.rd_addr_a];
    bus.rd_data_b  = (bus.rd_addr_b == '0) ? '0 : regs_q[bus.rd_addr_b];
    bus.rd_ready_b = (bus.rd_addr_b == '0) || !pending_eff[bus.rd_addr_b];
`ifdef RFSB_BYPASS_EN
    if (wb_hit && (bus.wb_addr == bus.rd_addr_a)) bus.rd_data_a = bus.wb_data;
    if (wb_hit && (bus.wb_addr == bus.rd_addr_b)) bus.rd_data_b = bus.wb_data;
`endif
  end

  assign bus.issue_ready = bus.rd_ready_a && bus.rd_ready_b &&
                           ((bus.issue_dest == '0) || !pending_eff[bus.issue_dest]);
  assign bus.wb_err      = wb_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
      pending_q <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      if (wb_hit) begin
        regs_q[bus.wb_addr]    <= bus.wb_data;
        pending_q[bus.wb_addr] <= 1'b0;
        if (!pending_q[bus.wb_addr]) wb_err_q <= 1'b1;
      end
      // Issued after the writeback clear so a same-index set wins.
      if (issue_fire) pending_q[bus.issue_dest] <= 1'b1;
    end
  end
endmodule
